// File: rtl/hazard_ctrl.sv
// ID-stage data-hazard controller: shadow EXE/MEM destination tracking, operand forwarding selects,
// load-use stall, ID/EXE bubble control and a saturating stall counter. Define HAZARD_FWD_EN to enable forwarding.
module hazard_ctrl (
  input  logic        clk,
  input  logic        clrn,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  id_rn,
  input  logic        id_wreg,
  input  logic        id_m2reg,
  input  logic        id_flush,
  output logic        stall,
  output logic        kill,
  output logic [1:0]  fwda,
  output logic [1:0]  fwdb,
  output logic [31:0] stall_cnt
);

`ifdef HAZARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  localparam logic [1:0] SEL_RF     = 2'b00;
  localparam logic [1:0] SEL_EX_ALU = 2'b01;
  localparam logic [1:0] SEL_MM_ALU = 2'b10;
  localparam logic [1:0] SEL_MM_LD  = 2'b11;

  // Shadow copy of the destination fields held in ID/EXE and EXE/MEM.
  logic [4:0]  ex_rn;
  logic        ex_wreg;
  logic        ex_m2reg;
  logic [4:0]  mm_rn;
  logic        mm_wreg;
  logic        mm_m2reg;
  logic [31:0] cnt_q;

  logic        a_ex;
  logic        a_mm;
  logic        b_ex;
  logic        b_mm;
  logic        load_use;
  logic        any_match;
  logic        stall_req;
  logic [1:0]  sel_a;
  logic [1:0]  sel_b;

  // Register 0 is hard-wired, so it never produces a dependency.
  assign a_ex = id_use_rs & ex_wreg & (ex_rn == id_rs) & (id_rs != 5'd0);
  assign a_mm = id_use_rs & mm_wreg & (mm_rn == id_rs) & (id_rs != 5'd0);
  assign b_ex = id_use_rt & ex_wreg & (ex_rn == id_rt) & (id_rt != 5'd0);
  assign b_mm = id_use_rt & mm_wreg & (mm_rn == id_rt) & (id_rt != 5'd0);

  assign load_use  = (a_ex | b_ex) & ex_m2reg;
  assign any_match = a_ex | a_mm | b_ex | b_mm;

  function automatic logic [1:0] fwd_sel(input logic m_ex, input logic m_mm, input logic mm_load);
    logic [1:0] sel;
    sel = SEL_RF;
    if (m_ex)
      sel = SEL_EX_ALU;
    else if (m_mm)
      sel = mm_load ? SEL_MM_LD : SEL_MM_ALU;
    return sel;
  endfunction

  assign sel_a = fwd_sel(a_ex, a_mm, mm_m2reg);
  assign sel_b = fwd_sel(b_ex, b_mm, mm_m2reg);

  // Without forwarding, every in-flight producer must drain past MEM before the consumer proceeds.
  always_comb begin
    stall_req = 1'b0;
    fwda      = SEL_RF;
    fwdb      = SEL_RF;
    if (FWD_EN) begin
      stall_req = load_use;
      if (!load_use) begin
        fwda = sel_a;
        fwdb = sel_b;
      end
    end else begin
      stall_req = any_match;
    end
  end

  // A resolved branch squashes the ID instruction, so there is nothing left to stall for.
  assign stall     = stall_req & ~id_flush;
  assign kill      = stall | id_flush;
  assign stall_cnt = cnt_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ex_rn    <= 5'd0;
      ex_wreg  <= 1'b0;
      ex_m2reg <= 1'b0;
      mm_rn    <= 5'd0;
      mm_wreg  <= 1'b0;
      mm_m2reg <= 1'b0;
    end else begin
      ex_rn    <= kill ? 5'd0 : id_rn;
      ex_wreg  <= kill ? 1'b0 : id_wreg;
      ex_m2reg <= kill ? 1'b0 : id_m2reg;
      mm_rn    <= ex_rn;
      mm_wreg  <= ex_wreg;
      mm_m2reg <= ex_m2reg;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      cnt_q <= 32'd0;
    else if (stall && (cnt_q != 32'hFFFF_FFFF))
      cnt_q <= cnt_q + 32'd1;
  end

endmodule
